// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU-facing memory responder.
// Holds the FSM state encoding, the default bus widths and the wait-state limit.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    localparam int WAIT_MAX   = 15;
    localparam int CNT_W      = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage : cpu_mem_pkg

// File: rtl/sp_ram.sv
// Synchronous single-port RAM, DEPTH x DATA_W, one access per enabled edge.
// The read register only updates on enabled reads, so it holds across writes.
module sp_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 192
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; clearing it would cost a write port per word
    // and the contents must survive a reset anyway. Non-blocking (<=) for all
    // clocked state so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule : sp_ram

// File: rtl/mem_responder.sv
// CPU memory responder: captures a request, inserts WAIT_CYCLES wait states,
// then performs the access and returns a one-cycle ready pulse with err.
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = 192,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;

    logic              cap_we;
    logic              cap_in_range;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic              ready_q;
    logic              err_q;
    logic              rd_valid_q;

    logic              start;
    logic              enter_resp;
    logic              sel_we;
    logic              sel_in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              ram_en;
    logic [DATA_W-1:0] ram_q;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: default assignment first so no path through the case leaves
    // state_d unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states the access happens on the capture edge itself,
    // so the RAM must see the live inputs rather than the capture registers.
    always_comb begin
        busy         = (state_q != ST_IDLE);
        start        = (state_q == ST_IDLE) && req;
        enter_resp   = reset && (state_d == ST_RESP) && (state_q != ST_RESP);
        sel_we       = cap_we;
        sel_addr     = cap_addr;
        sel_wdata    = cap_wdata;
        sel_in_range = cap_in_range;
        if (state_q == ST_IDLE) begin
            sel_we       = we;
            sel_addr     = addr;
            sel_wdata    = wdata;
            sel_in_range = in_range(addr);
        end
        ram_en = enter_resp && sel_in_range;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            cap_we       <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_in_range <= 1'b0;
        end else if (start) begin
            cnt_q        <= WAIT_LOAD;
            cap_we       <= we;
            cap_addr     <= addr;
            cap_wdata    <= wdata;
            cap_in_range <= in_range(addr);
        end else if (state_q == ST_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // ready/err are registered off RESP; rd_valid tracks whether the last
    // completed read hit storage, so out-of-range reads and reset show zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            ready_q <= (state_q == ST_RESP);
            err_q   <= (state_q == ST_RESP) && !cap_in_range;
            if (enter_resp && !sel_we) begin
                rd_valid_q <= sel_in_range;
            end
        end
    end

    sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clock  (clock),
        .en     (ram_en),
        .we     (sel_we),
        .addr   (sel_addr),
        .wdata  (sel_wdata),
        .rdata  (ram_q)
    );

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = rd_valid_q ? ram_q : '0;

endmodule : mem_responder

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter DEPTH, default 192, number of implemented words (1..2**ADDR_W).
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, wait states per access (0..15).
REQ-005 SHALL have port clock  input  1  the single clock; all state changes occur on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  input  1  CPU access request, sampled only in IDLE.
REQ-008 SHALL have port we  input  1  1 = write, 0 = read, captured with req.
REQ-009 SHALL have port addr  input  ADDR_W  word address, captured with req.
REQ-010 SHALL have port wdata  input  DATA_W  write data, captured with req.
REQ-011 SHALL have port rdata  output  DATA_W  read data, registered.
REQ-012 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port busy  output  1  high while a transaction is in progress.
REQ-014 SHALL have port err  output  1  out-of-range flag, valid with ready.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; busy = (state != IDLE).
REQ-016 In IDLE, req=1 at a rising edge SHALL capture we/addr/wdata, load the wait counter with WAIT_CYCLES, and go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-017 In WAIT, the counter SHALL decrement each cycle; the transition to RESP SHALL occur on the edge where the counter equals 1.
REQ-018 In RESP, ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-019 Latency: req sampled at edge N SHALL give ready high during the cycle after edge N+WAIT_CYCLES+1.
REQ-020 req, we, addr, wdata SHALL be ignored while busy=1; captured values SHALL NOT change mid-transaction.
REQ-021 req held high continuously SHALL start a new transaction on the IDLE edge after each RESP (minimum one IDLE cycle between transactions).
REQ-022 A write with captured addr < DEPTH SHALL update the array on the edge entering RESP.
REQ-023 A read with captured addr < DEPTH SHALL load rdata on the edge entering RESP.
REQ-024 rdata SHALL hold its value after ready until the next read completes; writes SHALL NOT change rdata.
REQ-025 A captured addr >= DEPTH SHALL assert err together with ready, suppress any write, and load rdata with 0 on reads.
REQ-026 err SHALL be 0 whenever ready=0.
REQ-027 A read following a write to the same address SHALL return the newly written data.

Reset
REQ-028 reset=0 SHALL asynchronously force state=IDLE, counter=0, ready=0, busy=0, err=0, rdata=0.
REQ-029 Reset mid-transaction SHALL abandon it; a pending write not yet committed SHALL NOT occur.
REQ-030 Array contents SHALL NOT be altered by reset.
REQ-031 After reset deasserts, the first rising edge with req=1 SHALL start a transaction.

Structure
REQ-032 Package cpu_mem_pkg SHALL hold the FSM state typedef, DATA_W/ADDR_W defaults, and the WAIT_CYCLES maximum constant.
REQ-033 The storage array SHALL be a sub-module sp_ram (synchronous single-port, DEPTH x DATA_W, no reset).
REQ-034 The FSM, wait counter, capture registers and range check SHALL reside in mem_responder.

Verification
REQ-035 WAIT_CYCLES=2: write addr=0x05 data=0xDEADBEEF at edge 10 -> ready high in cycle after edge 13, err=0, busy high cycles 10-13.
REQ-036 Then read addr=0x05 -> rdata=0xDEADBEEF with ready, err=0; rdata held after ready falls.
REQ-037 Read addr=0xC8 (>= DEPTH 192) -> ready with err=1, rdata=0; write to 0xC8 -> err=1, array unchanged.
REQ-038 req held high for 3 back-to-back reads -> exactly 3 ready pulses, each separated by >= 1 IDLE cycle; addr changes during busy ignored.
REQ-039 reset=0 asserted during WAIT of a write to 0x10 (data 0x12345678) -> outputs 0 immediately; later read of 0x10 returns prior contents.
REQ-040 WAIT_CYCLES=0: read sampled at edge N -> ready in cycle after edge N+1.
